// File: rtl/glyph_rom_pkg.sv
// Shared constants and port-id encoding for the glyph ROM read arbiter.
package glyph_rom_pkg;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 32;
  localparam int ROM_LAT = 2;

  typedef enum logic {
    PORT_DISP = 1'b0,
    PORT_BG   = 1'b1
  } port_id_e;
endpackage

// File: rtl/rom_rd_tag_pipe.sv
// Free-running {valid, id} shift register that tracks issued ROM reads until
// their data returns; never stalls, cleared by reset.
module rom_rd_tag_pipe
  import glyph_rom_pkg::*;
#(
  parameter int DEPTH = ROM_LAT + 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  input  port_id_e in_id,
  output logic     out_valid,
  output port_id_e out_id
);

  logic [DEPTH-1:0] valid_q;
  port_id_e         id_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) id_q[i] <= PORT_DISP;
    end else begin
      valid_q[0] <= in_valid;
      id_q[0]    <= in_id;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        id_q[i]    <= id_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_id    = id_q[DEPTH-1];

endmodule

// File: rtl/glyph_rom_arbiter.sv
// Two-port arbiter for the shared synchronous glyph ROM: display port has
// priority, background port gets a forced slot after STARVE_LIMIT losses.
module glyph_rom_arbiter
  import glyph_rom_pkg::*;
#(
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              starve_evt
);

  localparam int               CNT_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(STARVE_LIMIT);
  localparam bit               STRICT = (STARVE_LIMIT == 0);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_bg;
  logic             tag_valid;
  port_id_e         tag_in_id;
  port_id_e         tag_id;

  // Grants are gated by rst so nothing is accepted while reset is held.
  always_comb begin
    force_bg   = req0 && req1 && !STRICT && (starve_cnt == LIMIT);
    gnt0       = rst && req0 && !force_bg;
    gnt1       = rst && req1 && (!req0 || force_bg);
    starve_evt = rst && force_bg;
    tag_in_id  = gnt1 ? PORT_BG : PORT_DISP;
  end

  // Saturating loss counter; in strict mode LIMIT is 0 so it never moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!req1 || gnt1) begin
      starve_cnt <= '0;
    end else if (gnt0 && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr <= '0;
    end else if (gnt0) begin
      rom_addr <= addr0;
    end else if (gnt1) begin
      rom_addr <= addr1;
    end
  end

  rom_rd_tag_pipe #(
    .DEPTH (ROM_LAT + 1)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (gnt0 || gnt1),
    .in_id     (tag_in_id),
    .out_valid (tag_valid),
    .out_id    (tag_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
    end else begin
      rvalid0 <= tag_valid && (tag_id == PORT_DISP);
      rvalid1 <= tag_valid && (tag_id == PORT_BG);
      if (tag_valid) rdata <= rom_data;
    end
  end

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// Directed bench for glyph_rom_arbiter: two instances (STARVE_LIMIT 15 and 0),
// each fed by a two-register ROM model.
module tb_glyph_rom_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [5:0]  addr0, addr1;

  logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, evt_a;
  logic [31:0] rdata_a, rom_data_a;
  logic [5:0]  rom_addr_a, rom_aq_a;

  logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, evt_b;
  logic [31:0] rdata_b, rom_data_b;
  logic [5:0]  rom_addr_b, rom_aq_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b1;

  bit          exp_v0 [1024];
  bit          exp_v1 [1024];
  logic [31:0] exp_d  [1024];

  typedef struct {
    logic       r0;
    logic [5:0] a0;
    logic       r1;
    logic [5:0] a1;
    logic       g0;
    logic       g1;
    logic       ev;
  } vec_t;
  vec_t vt [12];

  glyph_rom_arbiter #(.STARVE_LIMIT(15)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_a), .rvalid0(rvalid0_a),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_a), .rvalid1(rvalid1_a),
    .rdata(rdata_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .starve_evt(evt_a)
  );

  glyph_rom_arbiter #(.STARVE_LIMIT(0)) u_dut_strict (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_b), .rvalid0(rvalid0_b),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_b), .rvalid1(rvalid1_b),
    .rdata(rdata_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .starve_evt(evt_b)
  );

  function automatic logic [31:0] rom_val(input int a);
    if (a == 5) return 32'hDEADBEEF;
    return {8'hC3, 8'(a), 8'(a * 7 + 1), 8'(~a)};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    rom_aq_a   <= rom_addr_a;
    rom_data_a <= rom_val(int'(rom_aq_a));
    rom_aq_b   <= rom_addr_b;
    rom_data_b <= rom_val(int'(rom_aq_b));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rvalid0", {31'd0, rvalid0_a}, {31'd0, exp_v0[cyc]});
      chk("rvalid1", {31'd0, rvalid1_a}, {31'd0, exp_v1[cyc]});
      if (exp_v0[cyc] || exp_v1[cyc]) chk("rdata", rdata_a, exp_d[cyc]);
    end
  end

  // Drive one cycle of requests, check the grant, and book the expected return.
  task automatic cycle(input logic r0, input logic [5:0] a0, input logic r1,
                       input logic [5:0] a1, input logic eg0, input logic eg1,
                       input logic eev, input string nm);
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    @(negedge clk);
    chk({nm, ".gnt0"}, {31'd0, gnt0_a}, {31'd0, eg0});
    chk({nm, ".gnt1"}, {31'd0, gnt1_a}, {31'd0, eg1});
    chk({nm, ".evt"},  {31'd0, evt_a},  {31'd0, eev});
    if (eg0) begin exp_v0[cyc + 4] = 1'b1; exp_d[cyc + 4] = rom_val(int'(a0)); end
    if (eg1) begin exp_v1[cyc + 4] = 1'b1; exp_d[cyc + 4] = rom_val(int'(a1)); end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".gnt0"},     {31'd0, gnt0_a},     32'd0);
    chk({nm, ".gnt1"},     {31'd0, gnt1_a},     32'd0);
    chk({nm, ".rvalid0"},  {31'd0, rvalid0_a},  32'd0);
    chk({nm, ".rvalid1"},  {31'd0, rvalid1_a},  32'd0);
    chk({nm, ".evt"},      {31'd0, evt_a},      32'd0);
    chk({nm, ".rom_addr"}, {26'd0, rom_addr_a}, 32'd0);
    chk({nm, ".rdata"},    rdata_a,             32'd0);
    chk({nm, ".gnt0_strict"}, {31'd0, gnt0_b},  32'd0);
  endtask

  initial begin
    int g0_cnt, g1_cnt, ev_cnt;
    for (int i = 0; i < 1024; i++) begin
      exp_v0[i] = 1'b0; exp_v1[i] = 1'b0; exp_d[i] = '0;
    end

    vt[0]  = '{1'b0, 6'd0,  1'b1, 6'd10, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 6'd11, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 6'd0,  1'b1, 6'd12, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 6'd13, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 6'd20, 1'b1, 6'd21, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 6'd0,  1'b1, 6'd22, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 6'd23, 1'b1, 6'd24, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 6'd25, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 6'd26, 1'b1, 6'd27, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b1, 6'd26, 1'b1, 6'd27, 1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b0, 6'd0,  1'b1, 6'd27, 1'b0, 1'b1, 1'b0};

    // Reset with requests pending: they must be ignored.
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 6'd3; addr1 = 6'd4;
    #2 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_reset_vals("reset");
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0; rst = 1'b1;

    // Single display read of ROM[5].
    cycle(1'b1, 6'd5, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, "t1");
    idle(5);
    chk("t1.rom_addr_hold", {26'd0, rom_addr_a}, 32'd5);

    for (int i = 0; i < 12; i++)
      cycle(vt[i].r0, vt[i].a0, vt[i].r1, vt[i].a1, vt[i].g0, vt[i].g1, vt[i].ev,
            $sformatf("vec%0d", i));
    idle(5);

    // Both ports requesting: 15 display wins, forced background slot, then display.
    for (int i = 1; i <= 20; i++)
      cycle(1'b1, 6'd30, 1'b1, 6'd40, (i != 16), (i == 16), (i == 16),
            $sformatf("t2_%0d", i));

    // Back-to-back background reads over the whole ROM.
    for (int i = 0; i < 64; i++)
      cycle(1'b0, 6'd0, 1'b1, 6'(i), 1'b0, 1'b1, 1'b0, $sformatf("t3_%0d", i));
    idle(5);

    // Reset with two reads in flight: they must vanish.
    cycle(1'b1, 6'd7, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, "t5a");
    cycle(1'b0, 6'd0, 1'b1, 6'd8, 1'b0, 1'b1, 1'b0, "t5b");
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    for (int i = cyc; i < 1024; i++) begin
      exp_v0[i] = 1'b0; exp_v1[i] = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      chk_reset_vals("t5_low");
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0; rst = 1'b1;
    cycle(1'b1, 6'd9, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, "t5_first");
    idle(6);

    // Strict-priority instance under permanent contention.
    chk_en = 1'b0;
    g0_cnt = 0; g1_cnt = 0; ev_cnt = 0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 6'd1; addr1 = 6'd2;
    repeat (100) begin
      @(negedge clk);
      if (gnt0_b) g0_cnt++;
      if (gnt1_b) g1_cnt++;
      if (evt_b)  ev_cnt++;
      @(posedge clk); #1;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("t6.gnt0_count", 32'(g0_cnt), 32'd100);
    chk("t6.gnt1_count", 32'(g1_cnt), 32'd0);
    chk("t6.evt_count",  32'(ev_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
